// File: rtl/branch_predictor_bht.sv
// Gshare branch predictor: a table of 2-bit saturating counters indexed by
// PC[INDEX_WIDTH+1:2] XOR global history. Predictions are combinational and
// side-effect free. Training comes from resolved branches in EX. After reset
// the table is swept to weak-not-taken (01) before the predictor goes live.
// GHR_WIDTH must lie in 1..INDEX_WIDTH.
module branch_predictor_bht #(
  parameter int INDEX_WIDTH = 7,
  parameter int GHR_WIDTH   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [31:0]            req_pc,
  output logic                   prediction,
  output logic [INDEX_WIDTH-1:0] pred_index,
  input  logic                   upd_valid,
  input  logic [INDEX_WIDTH-1:0] upd_index,
  input  logic                   upd_outcome,
  input  logic                   upd_prediction,
  output logic                   busy,
  output logic [31:0]            branch_count,
  output logic [31:0]            mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] init_ptr;
  logic [GHR_WIDTH-1:0]   ghr;
  logic [GHR_WIDTH-1:0]   ghr_shift;
  logic [1:0]             bht [ENTRIES];

  // req_valid only qualifies the request; the outputs are driven regardless.
  // The PC bits outside the index field do not take part in the hash.
  logic unused_bits;
  assign unused_bits = ^{req_valid, req_pc[31:INDEX_WIDTH+2], req_pc[1:0]};

  // Saturating counter step: toward 11 on taken, toward 00 on not-taken.
  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    end
    return nxt;
  endfunction

  // History shift; a one-bit history simply holds the latest outcome.
  generate
    if (GHR_WIDTH == 1) begin : g_ghr_one
      assign ghr_shift = upd_outcome;
    end else begin : g_ghr_multi
      assign ghr_shift = {ghr[GHR_WIDTH-2:0], upd_outcome};
    end
  endgenerate

  // The sweep state decodes directly from the state register.
  assign busy = (state == INIT);

  // Gshare index: PC word-address bits XOR zero-extended history.
  assign pred_index = req_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr);

  // Combinational prediction from pre-edge table state; forced NT while sweeping.
  always_comb begin
    prediction = 1'b0;
    if (state == READY) begin
      prediction = bht[pred_index][1];
    end else begin
      prediction = 1'b0;
    end
  end

  // Control FSM: init sweep pointer, global history and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= INIT;
      init_ptr         <= '0;
      ghr              <= '0;
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      case (state)
        INIT: begin
          init_ptr <= init_ptr + INDEX_WIDTH'(1);
          if (init_ptr == {INDEX_WIDTH{1'b1}}) begin
            state <= READY;
          end
        end
        READY: begin
          if (upd_valid) begin
            ghr          <= ghr_shift;
            branch_count <= branch_count + 32'd1;
            if (upd_prediction != upd_outcome) begin
              mispredict_count <= mispredict_count + 32'd1;
            end
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Counter table: sweep writes 01 during INIT, training updates in READY.
  // No reset on the array itself; the sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (!rst && state == INIT) begin
      bht[init_ptr] <= 2'b01;
    end else if (!rst && state == READY && upd_valid) begin
      bht[upd_index] <= sat_step(bht[upd_index], upd_outcome);
    end
  end

endmodule
